// File: rtl/lis_mem_ctrl_pkg.sv
// Shared op codes, access sizes and FSM states for the load/store controller
// and its alignment datapath.
package lis_mem_ctrl_pkg;

    localparam int LIS_OP_WIDTH   = 4;
    localparam int MEM_ADDR_WIDTH = 32;

    localparam logic [LIS_OP_WIDTH-1:0] LIS_LB  = 4'h0;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LH  = 4'h1;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LW  = 4'h2;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LBU = 4'h4;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LHU = 4'h5;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_SB  = 4'h8;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_SH  = 4'h9;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_SW  = 4'hA;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_NONE = 2'd3
    } lis_size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } lis_state_e;

    // SIZE_NONE marks an op code the controller does not implement.
    function automatic lis_size_e lis_op_size(input logic [LIS_OP_WIDTH-1:0] op);
        lis_size_e size;
        case (op)
            LIS_LB, LIS_LBU, LIS_SB: size = SIZE_BYTE;
            LIS_LH, LIS_LHU, LIS_SH: size = SIZE_HALF;
            LIS_LW, LIS_SW:          size = SIZE_WORD;
            default:                 size = SIZE_NONE;
        endcase
        return size;
    endfunction

    function automatic logic lis_op_is_store(input logic [LIS_OP_WIDTH-1:0] op);
        return (op == LIS_SB) || (op == LIS_SH) || (op == LIS_SW);
    endfunction

    function automatic logic lis_op_is_signed(input logic [LIS_OP_WIDTH-1:0] op);
        return (op == LIS_LB) || (op == LIS_LH) || (op == LIS_LW);
    endfunction

endpackage

// File: rtl/lis_align.sv
// Combinational lane logic for byte/half/word accesses: byte enables, store
// data replication, load data alignment and extension, misalignment detect.
module lis_align
    import lis_mem_ctrl_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    localparam int BE_WIDTH   = DATA_WIDTH / 8,
    localparam int OFF_WIDTH  = $clog2(BE_WIDTH)
) (
    input  logic [LIS_OP_WIDTH-1:0] op,
    input  logic [OFF_WIDTH-1:0]    off,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH-1:0]   rdata,
    output logic [BE_WIDTH-1:0]     be,
    output logic [DATA_WIDTH-1:0]   wdata_rep,
    output logic [DATA_WIDTH-1:0]   rdata_ext,
    output logic                    misaligned,
    output logic                    op_known,
    output logic                    is_store
);

    lis_size_e             size;
    logic                  is_signed;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] rep_b, rep_h, rep_w;
    logic [DATA_WIDTH-1:0] ext_b, ext_h, ext_w;

    assign size      = lis_op_size(op);
    assign is_signed = lis_op_is_signed(op);
    assign is_store  = lis_op_is_store(op);
    assign op_known  = (size != SIZE_NONE);
    assign shifted   = rdata >> {off, 3'b000};

    // Per-bit candidates for every size; the size decode below picks one.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        assign rep_b[i] = wdata[i % 8];
        assign rep_h[i] = wdata[i % 16];
        assign rep_w[i] = wdata[i % 32];
        if (i < 8) begin : g_lo8
            assign ext_b[i] = shifted[i];
        end else begin : g_hi8
            assign ext_b[i] = is_signed & shifted[7];
        end
        if (i < 16) begin : g_lo16
            assign ext_h[i] = shifted[i];
        end else begin : g_hi16
            assign ext_h[i] = is_signed & shifted[15];
        end
        if (i < 32) begin : g_lo32
            assign ext_w[i] = shifted[i];
        end else begin : g_hi32
            assign ext_w[i] = is_signed & shifted[31];
        end
    end

    always_comb begin
        be         = '0;
        misaligned = 1'b0;
        wdata_rep  = '0;
        rdata_ext  = '0;
        case (size)
            SIZE_BYTE: begin
                be        = BE_WIDTH'(1) << off;
                wdata_rep = rep_b;
                rdata_ext = ext_b;
            end
            SIZE_HALF: begin
                be         = BE_WIDTH'(2'b11) << off;
                misaligned = off[0];
                wdata_rep  = rep_h;
                rdata_ext  = ext_h;
            end
            SIZE_WORD: begin
                be         = BE_WIDTH'(4'hF) << off;
                misaligned = (off[1:0] != 2'b00);
                wdata_rep  = rep_w;
                rdata_ext  = ext_w;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lis_mem_ctrl.sv
// Single-outstanding load/store controller: accepts one request, runs the
// req/gnt/rvalid memory handshake and returns a registered, extended load result.
module lis_mem_ctrl
    import lis_mem_ctrl_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  ADDR_WIDTH = MEM_ADDR_WIDTH,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LIS_OP_WIDTH-1:0] op_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [DATA_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    done_o,
    output logic                    err_misaligned_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic                    mem_we_o,
    output logic [BE_WIDTH-1:0]     mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int OFF_WIDTH = $clog2(BE_WIDTH);

    lis_state_e state, state_n;

    logic [LIS_OP_WIDTH-1:0] op_q;
    logic [OFF_WIDTH-1:0]    off_q;
    logic                    err_mis_q;
    logic                    accept;

    logic [LIS_OP_WIDTH-1:0] align_op;
    logic [OFF_WIDTH-1:0]    align_off;
    logic [BE_WIDTH-1:0]     align_be;
    logic [DATA_WIDTH-1:0]   align_wdata;
    logic [DATA_WIDTH-1:0]   align_rdata;
    logic                    align_misaligned;
    logic                    align_op_known;
    logic                    align_is_store;
    logic [DATA_WIDTH-1:0]   addr_aligned;

    // The aligner sees the live request while idle and the latched one while
    // the load is in flight, so one instance serves both directions.
    assign align_op     = (state == ST_IDLE) ? op_i : op_q;
    assign align_off    = (state == ST_IDLE) ? addr_i[OFF_WIDTH-1:0] : off_q;
    assign accept       = valid_i & ready_o;
    assign addr_aligned = {addr_i[DATA_WIDTH-1:OFF_WIDTH], OFF_WIDTH'(0)};

    lis_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .op         (align_op),
        .off        (align_off),
        .wdata      (wdata_i),
        .rdata      (mem_rdata_i),
        .be         (align_be),
        .wdata_rep  (align_wdata),
        .rdata_ext  (align_rdata),
        .misaligned (align_misaligned),
        .op_known   (align_op_known),
        .is_store   (align_is_store)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n          = state;
        ready_o          = 1'b0;
        done_o           = 1'b0;
        err_misaligned_o = 1'b0;
        mem_req_o        = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    if (!align_op_known || align_misaligned) begin
                        state_n = ST_ERR;
                    end else begin
                        state_n = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_n = mem_we_o ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_n = ST_IDLE;
            end
            ST_ERR: begin
                done_o           = 1'b1;
                err_misaligned_o = err_mis_q;
                state_n          = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Memory-side outputs only change on an accepted, well-formed request, so
    // they stay stable for the whole REQ phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= '0;
            off_q       <= '0;
            err_mis_q   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
        end else begin
            if (accept) begin
                op_q      <= op_i;
                off_q     <= addr_i[OFF_WIDTH-1:0];
                err_mis_q <= align_op_known & align_misaligned;
                if (align_op_known && !align_misaligned) begin
                    mem_we_o    <= align_is_store;
                    mem_be_o    <= align_be;
                    mem_addr_o  <= ADDR_WIDTH'(addr_aligned);
                    mem_wdata_o <= align_wdata;
                end
            end
            if (state == ST_WAIT && mem_rvalid_i) begin
                rdata_o <= align_rdata;
            end
        end
    end

endmodule
